// File: rtl/starflux_gfx_pkg.sv
// Shared graphics definitions for the starflux game: screen size, 3-bit
// colour constants and the sprite drawer state encoding.
package starflux_gfx_pkg;

   localparam logic [8:0] SCREEN_W = 9'd160;
   localparam logic [7:0] SCREEN_H = 8'd120;

   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} draw_state_e;

endpackage

// File: rtl/sprite_pixel_scanner.sv
// Row-major px/py scanner over a W x H sprite box, shared by the sprite
// drawers. 'last' flags the bottom-right pixel; advancing on it wraps to 0.
module sprite_pixel_scanner #(
   parameter int W = 8,
   parameter int H = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear,
   input  logic       advance,
   output logic [3:0] px,
   output logic [3:0] py,
   output logic       last
);

   logic [3:0] px_q, px_d;
   logic [3:0] py_q, py_d;

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      if (clear) begin
         px_d = 4'd0;
         py_d = 4'd0;
      end else if (advance) begin
         if (px_q == 4'(W - 1)) begin
            px_d = 4'd0;
            py_d = (py_q == 4'(H - 1)) ? 4'd0 : py_q + 4'd1;
         end else begin
            px_d = px_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         px_q <= 4'd0;
         py_q <= 4'd0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign px   = px_q;
   assign py   = py_q;
   assign last = (px_q == 4'(W - 1)) && (py_q == 4'(H - 1));

endmodule

// File: rtl/enemy_sprite_drawer.sv
// Erases and redraws the enemy sprite on the 160x120 VGA adapter whenever its
// x position changes, one pixel per clock, and clears it when the game stops.
module enemy_sprite_drawer
   import starflux_gfx_pkg::*;
#(
   parameter int         SPRITE_W  = 8,
   parameter int         SPRITE_H  = 8,
   parameter logic [6:0] Y_POS     = 7'd10,
   parameter logic [2:0] COLOUR    = RED,
   parameter logic [2:0] BG_COLOUR = BLACK
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic [7:0] enemy_x,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       frame_done
);

   draw_state_e state_q, state_d;
   logic [7:0]  new_x_q, new_x_d;
   logic [7:0]  last_x_q, last_x_d;
   logic        drawn_valid_q, drawn_valid_d;
   logic        clear_only_q, clear_only_d;
   logic        last_pix_q, last_pix_d;
   logic [7:0]  vga_x_q, vga_x_d;
   logic [6:0]  vga_y_q, vga_y_d;
   logic [2:0]  vga_colour_q, vga_colour_d;
   logic        vga_plot_q, vga_plot_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;

   logic        present;
   logic        scan_adv;
   logic        scan_clr;
   logic        scan_last;
   logic [3:0]  px, py;
   logic [7:0]  base_x;
   logic [8:0]  pix_x9;
   logic [7:0]  pix_y8;

   // The scanner holds the pixel to be presented on the next cycle, so the
   // registered vga_* outputs line up exactly with the ERASE/DRAW states.
   sprite_pixel_scanner #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
      .clock   (clock),
      .resetn  (resetn),
      .clear   (scan_clr),
      .advance (scan_adv),
      .px      (px),
      .py      (py),
      .last    (scan_last)
   );

   assign scan_clr = (state_q == DONE);

   always_comb begin
      state_d       = state_q;
      new_x_d       = new_x_q;
      last_x_d      = last_x_q;
      drawn_valid_d = drawn_valid_q;
      clear_only_d  = clear_only_q;
      last_pix_d    = 1'b0;
      vga_x_d       = vga_x_q;
      vga_y_d       = vga_y_q;
      vga_colour_d  = vga_colour_q;
      vga_plot_d    = 1'b0;
      busy_d        = 1'b0;
      frame_done_d  = 1'b0;
      present       = 1'b0;
      scan_adv      = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable && (!drawn_valid_q || enemy_x != last_x_q)) begin
               new_x_d = enemy_x;
               state_d = drawn_valid_q ? ERASE : DRAW;
               present = 1'b1;
            end else if (!enable && drawn_valid_q) begin
               clear_only_d = 1'b1;
               state_d      = ERASE;
               present      = 1'b1;
            end
         end
         ERASE: begin
            if (last_pix_q) begin
               if (clear_only_q) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = DRAW;
                  present = 1'b1;
               end
            end else begin
               present = 1'b1;
            end
         end
         DRAW: begin
            if (last_pix_q) begin
               state_d      = DONE;
               frame_done_d = 1'b1;
            end else begin
               present = 1'b1;
            end
         end
         DONE: begin
            if (clear_only_q) begin
               drawn_valid_d = 1'b0;
               clear_only_d  = 1'b0;
            end else begin
               last_x_d      = new_x_q;
               drawn_valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pixel x is 9 bits so sprites hanging off the right edge clip rather than wrap.
      base_x = (state_d == ERASE) ? last_x_q : new_x_d;
      pix_x9 = {1'b0, base_x} + {5'd0, px};
      pix_y8 = {1'b0, Y_POS} + {4'd0, py};

      if (present) begin
         vga_x_d      = pix_x9[7:0];
         vga_y_d      = pix_y8[6:0];
         vga_colour_d = (state_d == ERASE) ? BG_COLOUR : COLOUR;
         vga_plot_d   = (pix_x9 < SCREEN_W) && (pix_y8 < SCREEN_H);
         busy_d       = 1'b1;
         last_pix_d   = scan_last;
         scan_adv     = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         new_x_q       <= 8'd0;
         last_x_q      <= 8'd0;
         drawn_valid_q <= 1'b0;
         clear_only_q  <= 1'b0;
         last_pix_q    <= 1'b0;
         vga_x_q       <= 8'd0;
         vga_y_q       <= 7'd0;
         vga_colour_q  <= 3'd0;
         vga_plot_q    <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         new_x_q       <= new_x_d;
         last_x_q      <= last_x_d;
         drawn_valid_q <= drawn_valid_d;
         clear_only_q  <= clear_only_d;
         last_pix_q    <= last_pix_d;
         vga_x_q       <= vga_x_d;
         vga_y_q       <= vga_y_d;
         vga_colour_q  <= vga_colour_d;
         vga_plot_q    <= vga_plot_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_enemy_sprite_drawer.sv
// Scoreboard bench for enemy_sprite_drawer: expected pixel streams are queued
// from a small screen model and compared against every busy cycle.
module tb_enemy_sprite_drawer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       enable;
   logic [7:0] enemy_x;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       frame_done;

   localparam logic [2:0] C_RED = 3'b100;
   localparam logic [2:0] C_BLK = 3'b000;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       p;
   } pix_t;

   pix_t exp_q[$];
   pix_t obs_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cap_busy, cap_fd, cap_fd_at, cap_stray, cap_timeout;

   enemy_sprite_drawer dut (
      .clock      (clock),
      .resetn     (resetn),
      .enable     (enable),
      .enemy_x    (enemy_x),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Screen model: 8x8 box at row 10, row-major, clipped at x>159 / y>119.
   task automatic push_scan(input int bx, input logic [2:0] col);
      for (int yy = 0; yy < 8; yy++) begin
         for (int xx = 0; xx < 8; xx++) begin
            pix_t e;
            int   xs;
            int   ys;
            xs = bx + xx;
            ys = 10 + yy;
            e.x = 8'(xs);
            e.y = 7'(ys);
            e.c = col;
            e.p = (xs < 160) && (ys < 120);
            exp_q.push_back(e);
         end
      end
   endtask

   // Records each busy cycle until frame_done has been seen plus 'tail' cycles.
   task automatic capture(input int limit, input int tail);
      pix_t o;
      obs_q.delete();
      cap_busy = 0; cap_fd = 0; cap_fd_at = 0; cap_stray = 0; cap_timeout = 0;
      for (int i = 1; ; i++) begin
         @(negedge clock);
         if (busy) begin
            o.x = vga_x; o.y = vga_y; o.c = vga_colour; o.p = vga_plot;
            obs_q.push_back(o);
            cap_busy++;
         end else if (vga_plot) begin
            cap_stray++;
         end
         if (frame_done) begin
            cap_fd++;
            if (cap_fd_at == 0) cap_fd_at = i;
         end
         if (cap_fd_at != 0 && i >= cap_fd_at + tail) break;
         if (i >= limit) begin
            cap_timeout = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b0; enemy_x = 8'd0;
      repeat (3) @(negedge clock);
      total++; if (vga_x !== 8'd0) begin bad++; $display("FAIL reset_vga_x got=%0d want=0", vga_x); end
      total++; if (vga_y !== 7'd0) begin bad++; $display("FAIL reset_vga_y got=%0d want=0", vga_y); end
      total++; if (vga_colour !== 3'd0) begin bad++; $display("FAIL reset_colour got=%0d want=0", vga_colour); end
      total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL reset_plot got=%b want=0", vga_plot); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
      resetn = 1'b1;
      repeat (4) @(negedge clock);
      total++; if (busy !== 1'b0 || vga_plot !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b plot=%b want=0 0", busy, vga_plot); end
   endtask

   task automatic test_first_draw();
      pix_t o, e;
      exp_q.delete();
      push_scan(20, C_RED);
      enemy_x = 8'd20; enable = 1'b1;
      capture(300, 3);
      total++; if (cap_timeout !== 0) begin bad++; $display("FAIL first_timeout got=%0d want=0", cap_timeout); end
      total++; if (cap_busy !== 64) begin bad++; $display("FAIL first_busy got=%0d want=64", cap_busy); end
      total++; if (cap_fd !== 1) begin bad++; $display("FAIL first_fd_count got=%0d want=1", cap_fd); end
      total++; if (cap_fd_at !== 65) begin bad++; $display("FAIL first_fd_cycle got=%0d want=65", cap_fd_at); end
      total++; if (cap_stray !== 0) begin bad++; $display("FAIL first_stray got=%0d want=0", cap_stray); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL first_pix got=%h want=%h", o, e);
         end
      end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL first_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_redraw();
      pix_t o, e;
      exp_q.delete();
      push_scan(20, C_BLK);
      push_scan(21, C_RED);
      enemy_x = 8'd21;
      capture(400, 3);
      total++; if (cap_timeout !== 0) begin bad++; $display("FAIL redraw_timeout got=%0d want=0", cap_timeout); end
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL redraw_busy got=%0d want=128", cap_busy); end
      total++; if (cap_fd !== 1) begin bad++; $display("FAIL redraw_fd_count got=%0d want=1", cap_fd); end
      total++; if (cap_fd_at !== 129) begin bad++; $display("FAIL redraw_fd_cycle got=%0d want=129", cap_fd_at); end
      total++; if (cap_stray !== 0) begin bad++; $display("FAIL redraw_stray got=%0d want=0", cap_stray); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL redraw_pix got=%h want=%h", o, e);
         end
      end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL redraw_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_clip();
      pix_t o, e;
      int   hidden;
      hidden = 0;
      exp_q.delete();
      push_scan(21, C_BLK);
      push_scan(156, C_RED);
      enemy_x = 8'd156;
      capture(400, 3);
      total++; if (cap_timeout !== 0) begin bad++; $display("FAIL clip_timeout got=%0d want=0", cap_timeout); end
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL clip_busy got=%0d want=128", cap_busy); end
      total++; if (cap_fd_at !== 129) begin bad++; $display("FAIL clip_fd_cycle got=%0d want=129", cap_fd_at); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         if (!o.p) hidden++;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL clip_pix got=%h want=%h", o, e);
         end
      end
      total++; if (hidden !== 32) begin bad++; $display("FAIL clip_hidden got=%0d want=32", hidden); end
   endtask

   task automatic test_back_to_back();
      pix_t o, e;
      // Move onto x=30 first (erase of the clipped sprite at 156).
      exp_q.delete();
      push_scan(156, C_BLK);
      push_scan(30, C_RED);
      enemy_x = 8'd30;
      capture(400, 0);
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL b2b_to30_busy got=%0d want=128", cap_busy); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL b2b_to30_pix got=%h want=%h", o, e);
         end
      end
      // 31 is latched; 32 arrives during the erase and must wait its turn.
      exp_q.delete();
      push_scan(30, C_BLK);
      push_scan(31, C_RED);
      enemy_x = 8'd31;
      fork
         capture(400, 0);
         begin
            repeat (12) @(negedge clock);
            enemy_x = 8'd32;
         end
      join
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL b2b_to31_busy got=%0d want=128", cap_busy); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL b2b_to31_pix got=%h want=%h", o, e);
         end
      end
      exp_q.delete();
      push_scan(31, C_BLK);
      push_scan(32, C_RED);
      capture(400, 3);
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL b2b_to32_busy got=%0d want=128", cap_busy); end
      total++; if (cap_fd_at !== 130) begin bad++; $display("FAIL b2b_to32_fd_cycle got=%0d want=130", cap_fd_at); end
      total++; if (cap_fd !== 1) begin bad++; $display("FAIL b2b_to32_fd_count got=%0d want=1", cap_fd); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL b2b_to32_pix got=%h want=%h", o, e);
         end
      end
   endtask

   task automatic test_clear();
      pix_t o, e;
      exp_q.delete();
      push_scan(32, C_BLK);
      push_scan(40, C_RED);
      enemy_x = 8'd40;
      capture(400, 3);
      total++; if (cap_busy !== 128) begin bad++; $display("FAIL clear_setup_busy got=%0d want=128", cap_busy); end
      exp_q.delete();
      push_scan(40, C_BLK);
      enable = 1'b0;
      capture(300, 25);
      total++; if (cap_timeout !== 0) begin bad++; $display("FAIL clear_timeout got=%0d want=0", cap_timeout); end
      total++; if (cap_busy !== 64) begin bad++; $display("FAIL clear_busy got=%0d want=64", cap_busy); end
      total++; if (cap_fd !== 1) begin bad++; $display("FAIL clear_fd_count got=%0d want=1", cap_fd); end
      total++; if (cap_fd_at !== 65) begin bad++; $display("FAIL clear_fd_cycle got=%0d want=65", cap_fd_at); end
      total++; if (cap_stray !== 0) begin bad++; $display("FAIL clear_stray got=%0d want=0", cap_stray); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL clear_pix got=%h want=%h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      pix_t o, e;
      int   act;
      enemy_x = 8'd50; enable = 1'b1;
      repeat (11) @(negedge clock);
      // Pixel 10 is px=2, py=1.
      total++;
      if (vga_plot !== 1'b1 || vga_x !== 8'd52 || vga_y !== 7'd11) begin
         bad++; $display("FAIL mid_pix10 got=%b/%0d/%0d want=1/52/11", vga_plot, vga_x, vga_y);
      end
      resetn = 1'b0;
      #1;
      total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL mid_rst_plot got=%b want=0", vga_plot); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
      total++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin bad++; $display("FAIL mid_rst_vga got=%h want=0", {vga_x, vga_y, vga_colour}); end
      enable = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      act = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (busy || vga_plot || frame_done) act++;
      end
      total++; if (act !== 0) begin bad++; $display("FAIL mid_idle_activity got=%0d want=0", act); end
      exp_q.delete();
      push_scan(50, C_RED);
      enable = 1'b1;
      capture(300, 3);
      total++; if (cap_busy !== 64) begin bad++; $display("FAIL mid_redraw_busy got=%0d want=64", cap_busy); end
      total++; if (cap_fd_at !== 65) begin bad++; $display("FAIL mid_redraw_fd_cycle got=%0d want=65", cap_fd_at); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (o.p !== e.p || (e.p && {o.x, o.y, o.c} !== {e.x, e.y, e.c})) begin
            bad++; $display("FAIL mid_redraw_pix got=%h want=%h", o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_redraw();
      test_clip();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enemy_sprite_drawer.md
Name: enemy_sprite_drawer

Overview:
Consumes the enemy's horizontal position from the movement handler and draws the enemy sprite on the 160x120 VGA adapter. On every position change it erases the old sprite with the background colour, then draws it at the new position, one pixel per clock. It sits between the movement handler and the VGA plot interface, and tells the rest of the game when a redraw completes.

Parameters:
SPRITE_W, 8, sprite width in pixels (1..16)
SPRITE_H, 8, sprite height in pixels (1..16)
Y_POS, 7'd10, fixed top row of the sprite
COLOUR, 3'b100, sprite colour (red)
BG_COLOUR, 3'b000, erase colour (black)

Ports:
clock  in  1  50 MHz board clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  game running; low requests the sprite be cleared
enemy_x  in  8  current enemy x position from the movement handler
vga_x  out  8  pixel x to the VGA adapter
vga_y  out  7  pixel y to the VGA adapter
vga_colour  out  3  pixel colour to the VGA adapter
vga_plot  out  1  write-enable to the VGA adapter
busy  out  1  high while in ERASE or DRAW
frame_done  out  1  one-cycle pulse when a redraw or clear completes

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE; drawn_valid=0; last_x=0; px=py=0.
  - All outputs are 0.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - If enable=1 and (drawn_valid=0 or enemy_x!=last_x): latch new_x<=enemy_x. Go to ERASE if drawn_valid=1, otherwise go to DRAW.
  - If enable=0 and drawn_valid=1: set clear_only=1 and go to ERASE.
  - Otherwise stay in IDLE.
- Pixel scan (ERASE and DRAW):
  - Row-major order: px runs 0..SPRITE_W-1 inside py 0..SPRITE_H-1, one pixel per clock.
  - The last pixel is px=SPRITE_W-1 and py=SPRITE_H-1. On it, px and py return to 0 and the next state is entered.
- ERASE:
  - Pixel k of the scan is presented on cycle k after the state is entered.
  - vga_x=last_x+px, vga_y=Y_POS+py, vga_colour=BG_COLOUR.
  - After the last pixel: go to DONE if clear_only=1, otherwise go to DRAW.
- DRAW:
  - Same scan, using new_x and COLOUR.
  - After the last pixel: go to DONE.
- DONE (one cycle):
  - frame_done=1.
  - After a draw: last_x<=new_x, drawn_valid<=1.
  - After a clear: drawn_valid<=0, clear_only<=0.
  - Then go to IDLE.
- Output timing:
  - vga_* are registered.
  - vga_plot=1 exactly on the cycles that present a visible pixel.
  - busy = (state==ERASE or state==DRAW).
- Clipping:
  - Pixel x is computed 9 bits wide. If x>159 or Y_POS+py>119, that cycle has vga_plot=0; the scan still advances and the cycle count is unchanged.
  - There is no wrap-around onto the left edge.
- Cycle counts:
  - A full redraw takes 2*SPRITE_W*SPRITE_H+1 cycles from leaving IDLE to DONE: 129 with the defaults.
  - The first draw and a clear each take SPRITE_W*SPRITE_H+1 cycles.
- Simultaneous events and mid-operation changes:
  - enemy_x changes while busy are ignored. The new value is compared on return to IDLE, so only the latest position is drawn and intermediate positions are skipped.
  - enable falling mid-operation does not abort the pass. The clear happens from IDLE afterwards.
  - resetn asserted mid-scan aborts immediately, with vga_plot=0. Pixels already plotted stay on screen; the screen clear is owned by the VGA/reset logic.
- The movement handler changes x at 2 Hz, so the drawer is never overrun.

Decomposition:
- Shared package starflux_gfx_pkg:
  - SCREEN_W=160, SCREEN_H=120.
  - Colour constants (BLACK, RED, ...).
  - Drawer state enum (IDLE, ERASE, DRAW, DONE).
- One sub-module, sprite_pixel_scanner: px/py counters with clear, advance and last outputs, parameterised by W and H. It is reused by the future player and bullet drawers.

Test Plan:
- Reset, then enable=1, enemy_x=20 -> DRAW only. 64 plots with colour 3'b100 at x 20..27, y 10..17 in row-major order. frame_done pulses on cycle 65. last_x=20.
- After that, enemy_x=21 -> 64 plots of 3'b000 at x 20..27, then 64 plots of 3'b100 at x 21..28. busy is high for exactly 128 cycles. frame_done is high for 1 cycle.
- enemy_x=156 drawn -> only x 156..159 plotted; 32 cycles have vga_plot=0. Total DRAW length is still 64 cycles.
- enemy_x steps 30->31->32 during an ERASE -> the current pass completes at 31. The next redraw targets 32. 31 is never redrawn twice.
- enable=0 with a sprite at x=40 -> 64 BG_COLOUR plots at x 40..47, frame_done pulses, drawn_valid=0. The block then stays idle with no plots.
- resetn pulsed low at DRAW pixel 10 -> outputs go to 0 in the same cycle, state is IDLE. The next enable triggers a DRAW-only pass (drawn_valid=0).
